// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the signals between the two bus requesters,
// the arbiter and the shared memory port.
//   cpu_*  : CPU request/response (req/we/addr/wdata in, rdata/ack out)
//   dma_*  : DMA request/response, same meaning as the CPU group
//   mem_*  : single memory port (we/addr/wdata out, combinational rdata in)
// Modports:
//   slave  : arbiter view (requests in, responses and memory controls out)
//   master : requester/memory-side view (the mirror of slave)
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the
// multicycle CPU and a second master (boot loader / DMA). Accesses are
// serialised as IDLE -> ACCESS -> RESP (one transaction per 3 cycles).
// The CPU wins ties unless it has already taken MAXBURST consecutive grants
// while the DMA was waiting, which bounds DMA starvation.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : mem_arbiter_if.slave (cpu_*, dma_*, mem_* signal groups)
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAXBURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAXBURST);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic          owner;      // 0 = CPU, 1 = DMA
    logic [CW-1:0] cnt;        // consecutive CPU grants while DMA waited
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    logic          cpu_win;
    logic          owner_we;
    logic [AW-1:0] owner_addr;
    logic [DW-1:0] owner_wdata;

    assign cpu_win     = bus.cpu_req && (!bus.dma_req || (cnt < CMAX));
    assign owner_we    = owner ? bus.dma_we    : bus.cpu_we;
    assign owner_addr  = owner ? bus.dma_addr  : bus.cpu_addr;
    assign owner_wdata = owner ? bus.dma_wdata : bus.cpu_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            cnt         <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_win) begin
                        owner <= 1'b0;
                        state <= ACCESS;
                        if (bus.dma_req)
                            cnt <= (cnt == CMAX) ? CMAX : cnt + CW'(1);
                        else
                            cnt <= '0;
                    end else if (bus.dma_req) begin
                        owner <= 1'b1;
                        cnt   <= '0;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!owner_we) begin
                        if (owner)
                            dma_rdata_q <= bus.mem_rdata;
                        else
                            cpu_rdata_q <= bus.mem_rdata;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory controls decode the state register directly; mem_we is also
    // gated by reset so a reset landing mid-ACCESS never commits a write.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state == ACCESS) begin
            bus.mem_we    = owner_we & reset;
            bus.mem_addr  = owner_addr;
            bus.mem_wdata = owner_wdata;
        end
    end

    always_comb begin
        bus.cpu_ack   = (state == RESP) && !owner;
        bus.dma_ack   = (state == RESP) &&  owner;
        bus.cpu_rdata = cpu_rdata_q;
        bus.dma_rdata = dma_rdata_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a word memory
// model on the memory port and a scoreboard of expected responses.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .MAXBURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // word memory model, indexed by byte address bits [9:2]
    logic [31:0] model [256];
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1)
            model[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else if (pl_en)
            model[pl_addr[9:2]] <= pl_data;
    end
    assign bus.mem_rdata = model[bus.mem_addr[9:2]];

    // protocol monitors: both acks high, or same ack high twice in a row
    int   ack_both = 0;
    int   ack_rep  = 0;
    logic prev_cpu_ack = 1'b0;
    logic prev_dma_ack = 1'b0;
    always @(negedge clk) begin
        if (bus.cpu_ack === 1'b1 && bus.dma_ack === 1'b1) ack_both++;
        if ((bus.cpu_ack === 1'b1 && prev_cpu_ack) || (bus.dma_ack === 1'b1 && prev_dma_ack)) ack_rep++;
        prev_cpu_ack = (bus.cpu_ack === 1'b1);
        prev_dma_ack = (bus.dma_ack === 1'b1);
    end

    typedef struct packed {
        logic        port;   // 0 = CPU, 1 = DMA
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Single-port transaction: starts at a negedge with the arbiter idle,
    // returns at the next negedge after the ack (arbiter idle again).
    task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd,
                       output int cycles, output int we_cycles,
                       output bit other_ack, output bit timeout);
        cycles = 0; we_cycles = 0; other_ack = 1'b0; timeout = 1'b1; rd = '0;
        if (!port) begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end else begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.mem_we === 1'b1) we_cycles++;
            if ((port ? bus.cpu_ack : bus.dma_ack) === 1'b1) other_ack = 1'b1;
            if ((port ? bus.dma_ack : bus.cpu_ack) === 1'b1) begin
                rd = port ? bus.dma_rdata : bus.cpu_rdata;
                timeout = 1'b0;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] z;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;  bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h100; bus.dma_wdata = 32'h0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            z = bus.mem_addr | bus.mem_wdata | bus.cpu_rdata | bus.dma_rdata;
            checks++;
            if ({bus.cpu_ack, bus.dma_ack, bus.mem_we} !== 3'b000 || z !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs cyc%0d: acks/we=%b%b%b or-of-buses=%h, expected all 0",
                         i, bus.cpu_ack, bus.dma_ack, bus.mem_we, z);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL reset_first_grant: cpu_ack=%b mem_addr=%h, expected 0 and 00000040",
                     bus.cpu_ack, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.cpu_ack, bus.dma_ack} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_ack: cpu/dma ack=%b%b, expected 10", bus.cpu_ack, bus.dma_ack);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [31:0] rd; int cyc, wec; bit oth, to; exp_t e;
        // write: rdata register must keep its value (0 from the reset-test read)
        sb.push_back('{port: 1'b0, data: 32'h0});
        txn(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, rd, cyc, wec, oth, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != 2) begin
            failures++;
            $display("FAIL wr_latency: timeout=%0d cycles=%0d, expected 0 and 2", to, cyc);
        end
        checks++;
        if (wec != 1) begin
            failures++;
            $display("FAIL wr_mem_we_cycles: got %0d, expected 1", wec);
        end
        checks++;
        if (model[8'h10] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_mem_content: got %h, expected deadbeef", model[8'h10]);
        end
        checks++;
        if (rd !== e.data) begin
            failures++;
            $display("FAIL wr_rdata_kept: got %h, expected %h", rd, e.data);
        end
        sb.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        txn(1'b0, 1'b0, 32'h40, 32'h0, rd, cyc, wec, oth, to);
        e = sb.pop_front();
        checks++;
        if (to || rd !== e.data || wec != 0) begin
            failures++;
            $display("FAIL rd_data: timeout=%0d rdata=%h we_cycles=%0d, expected 0 %h 0", to, rd, e.data, wec);
        end
        sb.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        txn(1'b0, 1'b1, 32'h44, 32'h11111111, rd, cyc, wec, oth, to);
        e = sb.pop_front();
        checks++;
        if (to || rd !== e.data) begin
            failures++;
            $display("FAIL wr2_rdata_kept: timeout=%0d rdata=%h, expected 0 %h", to, rd, e.data);
        end
    endtask

    task automatic test_dma_alone;
        logic [31:0] rd; int cyc, wec; bit oth, to; exp_t e;
        sb.push_back('{port: 1'b1, data: 32'h12345678});
        txn(1'b1, 1'b0, 32'h100, 32'h0, rd, cyc, wec, oth, to);
        e = sb.pop_front();
        checks++;
        if (to || cyc != 2 || oth) begin
            failures++;
            $display("FAIL dma_latency: timeout=%0d cycles=%0d cpu_ack_seen=%0d, expected 0 2 0", to, cyc, oth);
        end
        checks++;
        if (rd !== e.data) begin
            failures++;
            $display("FAIL dma_rdata: got %h, expected %h", rd, e.data);
        end
    endtask

    task automatic test_simultaneous;
        exp_t e; bit cpu_done, dma_done; bit ack_port; logic [31:0] rd;
        cpu_done = 1'b0; dma_done = 1'b0;
        sb.push_back('{port: 1'b0, data: 32'hDEADBEEF});
        sb.push_back('{port: 1'b1, data: 32'h12345678});
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h200; bus.cpu_wdata = 32'hCAFEF00D;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h100; bus.dma_wdata = 32'h0;
        for (int i = 0; i < 30 && !(cpu_done && dma_done); i++) begin
            @(negedge clk);
            if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
                ack_port = (bus.dma_ack === 1'b1);
                rd = ack_port ? bus.dma_rdata : bus.cpu_rdata;
                e = sb.pop_front();
                checks++;
                if (ack_port !== e.port || rd !== e.data) begin
                    failures++;
                    $display("FAIL simul_order: port=%0d data=%h, expected port=%0d data=%h",
                             ack_port, rd, e.port, e.data);
                end
                if (ack_port) begin dma_done = 1'b1; bus.dma_req = 1'b0; end
                else begin cpu_done = 1'b1; bus.cpu_req = 1'b0; end
            end
        end
        checks++;
        if (!(cpu_done && dma_done)) begin
            failures++;
            $display("FAIL simul_complete: cpu_done=%0d dma_done=%0d, expected 1 1", cpu_done, dma_done);
            sb.delete();
        end
        checks++;
        if (model[8'h80] !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL simul_cpu_write: got %h, expected cafef00d", model[8'h80]);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness;
        exp_t e; int n_ack, want_cyc; bit ack_port; logic [31:0] rd;
        logic [9:0] pattern;
        pattern = 10'b1000010000;  // bit k = port of grant k (LSB first): C C C C D C C C C D
        for (int k = 0; k < 10; k++)
            sb.push_back('{port: pattern[k], data: pattern[k] ? 32'h12345678 : 32'hDEADBEEF});
        n_ack = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;  bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h100; bus.dma_wdata = 32'h0;
        for (int cyc = 1; cyc <= 60 && n_ack < 10; cyc++) begin
            @(negedge clk);
            if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
                ack_port = (bus.dma_ack === 1'b1);
                rd = ack_port ? bus.dma_rdata : bus.cpu_rdata;
                want_cyc = 2 + 3 * n_ack;
                e = sb.pop_front();
                checks++;
                if (ack_port !== e.port || rd !== e.data || cyc != want_cyc) begin
                    failures++;
                    $display("FAIL fair_grant%0d: port=%0d data=%h cycle=%0d, expected port=%0d data=%h cycle=%0d",
                             n_ack, ack_port, rd, cyc, e.port, e.data, want_cyc);
                end
                n_ack++;
            end
        end
        checks++;
        if (n_ack != 10) begin
            failures++;
            $display("FAIL fair_count: got %0d grants, expected 10", n_ack);
            sb.delete();
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_access;
        logic [31:0] rd; int cyc, wec, acks; bit oth, to; exp_t e;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h55AA55AA;
        @(negedge clk);
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h80) begin
            failures++;
            $display("FAIL rst_acc_pre: mem_we=%b mem_addr=%h, expected 1 00000080", bus.mem_we, bus.mem_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_acc_we_gated: mem_we=%b, expected 0", bus.mem_we);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || bus.cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_acc_no_ack: acks=%0d cpu_rdata=%h, expected 0 00000000", acks, bus.cpu_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (model[8'h20] !== 32'h0) begin
            failures++;
            $display("FAIL rst_acc_mem: got %h, expected 00000000", model[8'h20]);
        end
        sb.push_back('{port: 1'b0, data: 32'h0});
        txn(1'b0, 1'b0, 32'h80, 32'h0, rd, cyc, wec, oth, to);
        e = sb.pop_front();
        checks++;
        if (to || rd !== e.data) begin
            failures++;
            $display("FAIL rst_acc_readback: timeout=%0d rdata=%h, expected 0 %h", to, rd, e.data);
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (ack_both != 0 || ack_rep != 0) begin
            failures++;
            $display("FAIL ack_protocol: both_high=%0d repeated=%0d, expected 0 0", ack_both, ack_rep);
        end
    endtask

    initial begin
        reset = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        preload(32'h0,   32'h0);
        preload(32'h40,  32'h0);
        preload(32'h80,  32'h0);
        preload(32'h100, 32'h12345678);
        test_reset;
        test_write_read;
        test_dma_alone;
        test_simultaneous;
        test_fairness;
        test_reset_access;
        test_protocol;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single unified instruction/data memory between the multicycle RISC-V core and a second bus master (boot loader / DMA engine). It serialises word accesses from both requesters onto one memory port with a req/ack handshake, registered read data and a bounded-starvation priority scheme. It sits between the requesters and the memory unit, replacing the direct core-to-memory connection.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAXBURST, 4, max consecutive CPU grants while DMA is waiting (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- cpu_req  input  1  CPU access request; held until cpu_ack
- cpu_we  input  1  CPU write enable (1 = write, 0 = read)
- cpu_addr  input  AW  CPU byte address
- cpu_wdata  input  DW  CPU write data
- cpu_rdata  output  DW  CPU read data, valid while cpu_ack=1
- cpu_ack  output  1  one-cycle completion pulse to CPU
- dma_req / dma_we / dma_addr / dma_wdata  input  1/1/AW/DW  same meaning, DMA port
- dma_rdata  output  DW  DMA read data, valid while dma_ack=1
- dma_ack  output  1  one-cycle completion pulse to DMA
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory combinational read data

## Operation
- FSM states IDLE, ACCESS, RESP; owner register (0 = CPU, 1 = DMA); starvation counter cnt (0..MAXBURST).
- IDLE: if any req, pick winner, latch owner, go ACCESS; else stay IDLE.
- Winner rule: only one req → that one. Both req → CPU if cnt < MAXBURST, else DMA.
- cnt: CPU granted while dma_req=1 → cnt+1 (saturates at MAXBURST); DMA granted → cnt=0; CPU granted while dma_req=0 → cnt=0.
- ACCESS: mem_addr/mem_wdata = owner's addr/wdata; mem_we = owner's we AND reset (no write in a reset cycle); owner's mem_rdata captured into owner's rdata register at the clock edge (reads only; writes leave rdata unchanged). Go RESP.
- RESP: owner's ack=1 for exactly this cycle; other ack=0. Go IDLE unconditionally.
- Outside ACCESS: mem_we=0, mem_addr=0, mem_wdata=0.
- Requesters hold req, we, addr, wdata stable from req rise until ack; req is dropped or a new request presented in the cycle after ack. req sampled during ACCESS/RESP is ignored for arbitration.
- Non-owner's req is never lost; it waits in IDLE for the next arbitration.
- Addresses pass through unmodified; no alignment checking.

## Timing
- Reset (reset=0 at edge): state=IDLE, owner=0, cnt=0, cpu_rdata=dma_rdata=0, cpu_ack=dma_ack=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-ACCESS aborts: no write, no ack, rdata not updated.
- Latency: req seen in IDLE at cycle N → ACCESS in N+1 → ack and rdata valid in N+2. Idle-to-ack = 2 cycles; throughput one transaction per 3 cycles.
- Acks are registered-state decodes: never both high; never high two consecutive cycles for the same port.
- Worst-case DMA wait with continuous CPU traffic: MAXBURST CPU transactions (3·MAXBURST cycles) before DMA grant.

## Test plan
- Reset: hold reset=0 three cycles with both reqs high → all outputs 0, no ack; release → CPU granted first, cpu_ack two cycles after first IDLE sample.
- CPU write then read: cpu_we=1, addr 0x40, wdata 0xDEADBEEF → mem_we=1 for exactly one cycle, cpu_ack next cycle; then read 0x40 → cpu_rdata=0xDEADBEEF with cpu_ack.
- DMA alone: dma read of 0x100 preloaded 0x12345678 → dma_rdata=0x12345678, dma_ack 2 cycles after request, cpu_ack stays 0.
- Fairness: MAXBURST=4, both reqs continuously high → grant sequence CPU,CPU,CPU,CPU,DMA,CPU…; cnt returns to 0 after DMA grant.
- Simultaneous single requests with dma_req low before → CPU wins, DMA served in next arbitration, its data unaffected by CPU write to a different address.
- Reset during ACCESS of a CPU write to 0x80 (old 0x0) → 0x80 still reads 0x0; no ack issued.
